// File: rtl/blink_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : blink_sequencer
// Description: Shared CW-bit blink time base with an IDLE/RUN/PAUSE control
//              FSM. NUM_CH channels each produce a registered blink taken from
//              bit TAP of (count + per-channel offset). Offsets are written
//              through a valid/ready config port that is open whenever the
//              sequencer is not running.
//              Optional feature macro: BLINK_SEQ_ROTATE_EN. When it is defined,
//              the offsets rotate by one channel on every count wrap in RUN.
// Revision   : 1.0 - initial release
// ============================================================================
module blink_sequencer #(
    parameter int NUM_CH = 4,
    parameter int CW     = 16,
    parameter int TAP    = 9
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [CW-1:0]             cfg_offset,
    output logic [CW-1:0]             count_out,
    output logic [NUM_CH-1:0]         blink_out,
    output logic [1:0]                state_out
);

    localparam int C_CHW         = $clog2(NUM_CH);
    // Reset offsets spread the channels evenly over one period of bit TAP.
    localparam int C_PHASE_SHIFT = TAP + 1 - C_CHW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_count;
    logic [CW-1:0]       r_offset [NUM_CH];
    logic [NUM_CH-1:0]   r_blink;
    logic                w_advance;
    logic                w_clear;
    logic                w_cfg_write;

    assign w_advance   = (r_state == S_RUN) && ena;
    // Leaving PAUSE for IDLE is the only transition that clears the count.
    assign w_clear     = (r_state == S_PAUSE) && (w_state_nxt == S_IDLE);
    assign cfg_ready   = (r_state != S_RUN);
    assign w_cfg_write = cfg_valid && cfg_ready;

`ifdef BLINK_SEQ_ROTATE_EN
    logic w_wrap;
    assign w_wrap = w_advance && (r_count == {CW{1'b1}});
`endif

    // Next-state decode; stop outranks start whenever both are asserted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Time base: advances only in RUN with enable, wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_clear) begin
            r_count <= '0;
        end else if (w_advance) begin
            r_count <= r_count + CW'(1);
        end
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            localparam logic [C_CHW-1:0] c_idx     = C_CHW'(i);
            localparam logic [CW-1:0]    c_rst_off = CW'(i) << C_PHASE_SHIFT;
            localparam int               c_prev    = (i + NUM_CH - 1) % NUM_CH;

            logic [CW-1:0] w_sum;
            assign w_sum = r_count + r_offset[i];

            // Channel offset: config write when the port is open, rotation on wrap.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_offset[i] <= c_rst_off;
                end else if (w_cfg_write && (cfg_ch == c_idx)) begin
                    r_offset[i] <= cfg_offset;
`ifdef BLINK_SEQ_ROTATE_EN
                end else if (w_wrap) begin
                    r_offset[i] <= r_offset[c_prev];
`endif
                end
            end

            // Blink bit: cleared in IDLE, tracks the sum in RUN, frozen in PAUSE.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_blink[i] <= 1'b0;
                end else if (r_state == S_IDLE) begin
                    r_blink[i] <= 1'b0;
                end else if (r_state == S_RUN) begin
                    r_blink[i] <= w_sum[TAP];
                end
            end
        end
    endgenerate

    assign count_out = r_count;
    assign blink_out = r_blink;
    assign state_out = r_state;

endmodule
`default_nettype wire

// File: tb/tb_blink_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : tb_blink_sequencer
// Description: Scoreboard bench for blink_sequencer. A driver applies directed
//              and random stimulus, a reference model predicts every cycle's
//              outputs into a queue, and a monitor pops and compares.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_blink_sequencer;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        start;
    logic        stop;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_offset;
    logic [15:0] count_out;
    logic [3:0]  blink_out;
    logic [1:0]  state_out;

    blink_sequencer #(
        .NUM_CH (4),
        .CW     (16),
        .TAP    (9)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .stop       (stop),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_offset (cfg_offset),
        .count_out  (count_out),
        .blink_out  (blink_out),
        .state_out  (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  st;
        logic [15:0] cnt;
        logic [3:0]  blk;
        logic        rdy;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state: 0 IDLE, 1 RUN, 2 PAUSE.
    int   m_state;
    int   m_count;
    bit [3:0] m_blink;
    int   m_off [4];

    task automatic compare(input exp_t e, input string name);
        n_vec++;
        if (state_out !== e.st || count_out !== e.cnt || blink_out !== e.blk || cfg_ready !== e.rdy) begin
            n_bad++;
            $display("FAIL %s t=%0t: got state=%0d count=%0d blink=%b ready=%b, expected state=%0d count=%0d blink=%b ready=%b",
                     name, $time, state_out, count_out, blink_out, cfg_ready, e.st, e.cnt, e.blk, e.rdy);
        end
    endtask

    // Model of one clock edge, derived from the behavioural rules.
    task automatic model_edge(input bit e, input bit s, input bit p, input bit v,
                              input int ch, input int off);
        int ns;
        bit wrap;
        int tmp;
        exp_t x;
        if (!rst_n) begin
            m_state = 0;
            m_count = 0;
            m_blink = '0;
            for (int i = 0; i < 4; i++) m_off[i] = i * 256;
        end else begin
            wrap = 1'b0;
            ns   = m_state;
            if (p) begin
                if (m_state == 1) ns = 2;
                else if (m_state == 2) ns = 0;
            end else if (s && m_state != 1) begin
                ns = 1;
            end
            if (m_state == 1) begin
                for (int i = 0; i < 4; i++)
                    m_blink[i] = (((m_count + m_off[i]) % 65536) >> 9) & 1;
            end else if (m_state == 0) begin
                m_blink = '0;
            end
            if (v && m_state != 1) m_off[ch] = off;
            if (m_state == 1 && e) begin
                wrap    = (m_count == 65535);
                m_count = (m_count + 1) % 65536;
            end
            if (m_state == 2 && ns == 0) m_count = 0;
`ifdef BLINK_SEQ_ROTATE_EN
            if (wrap) begin
                tmp = m_off[3];
                for (int i = 3; i > 0; i--) m_off[i] = m_off[i-1];
                m_off[0] = tmp;
            end
`endif
            m_state = ns;
        end
        x.st  = 2'(m_state);
        x.cnt = 16'(m_count);
        x.blk = m_blink;
        x.rdy = (m_state != 1);
        q.push_back(x);
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass, predict.
    task automatic step(input bit e, input bit s, input bit p, input bit v,
                        input int ch, input int off);
        ena        = e;
        start      = s;
        stop       = p;
        cfg_valid  = v;
        cfg_ch     = 2'(ch);
        cfg_offset = 16'(off);
        @(posedge clk);
        model_edge(e, s, p, v, ch, off);
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit e);
        for (int k = 0; k < n; k++) step(e, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are presented every cycle; check one prediction per edge.
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            compare(e, "cycle");
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : drive
        exp_t z;
        rst_n = 1'b0;
        ena = 0; start = 0; stop = 0; cfg_valid = 0; cfg_ch = '0; cfg_offset = '0;
        @(negedge clk);

        // Reset values.
        run(2, 1);
        rst_n = 1'b1;
        run(2, 1);

        // Free run from reset: phase spread shows in blink timing.
        step(1, 1, 0, 0, 0, 0);
        run(1100, 1);

        // Pause at a known count, then return to IDLE.
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        run(300, 1);
        step(1, 0, 1, 0, 0, 0);
        run(10, 1);
        step(1, 0, 1, 0, 0, 0);
        run(5, 1);

        // Config ignored in RUN, accepted in PAUSE.
        step(1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) step(1, 0, 0, 1, 2, 16'h0200);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 2, 16'h0200);
        step(1, 1, 0, 0, 0, 0);
        run(600, 1);

        // Start and write together from PAUSE.
        step(1, 0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 1, 16'h0321);
        run(600, 1);

        // Start and stop together in IDLE, then in RUN.
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        run(3, 1);
        step(1, 1, 0, 0, 0, 0);
        run(5, 1);
        step(1, 1, 1, 0, 0, 0);
        run(3, 1);

        // Enable low mid-RUN.
        step(1, 1, 0, 0, 0, 0);
        run(20, 1);
        run(50, 0);
        run(20, 1);

        // Random stimulus.
        for (int k = 0; k < 2000; k++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)));
        end

        // Asynchronous reset mid-RUN: outputs drop without a clock edge.
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        run(700, 1);
        #2;
        rst_n = 1'b0;
        #1;
        z.st = 2'd0; z.cnt = 16'd0; z.blk = 4'd0; z.rdy = 1'b1;
        compare(z, "async_reset");
        @(negedge clk);
        run(1, 1);
        rst_n = 1'b1;
        run(2, 1);

        // Long run through the count wrap; offsets afterwards show in blink.
        step(1, 1, 0, 0, 0, 0);
        run(65536 + 1100, 1);

        run(2, 0);
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
